// File: rtl/dsp_nco_pkg.sv
// Shared constants for the NCO phase accumulator: LFSR seed/taps, update modes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dsp_nco_pkg;

  // Galois LFSR for x^16+x^14+x^13+x^11+1 in right-shift form: when the
  // bit shifted out is 1, bits 15,13,12,10 are flipped (mask 16'hB400).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Frequency/phase word update policy.
  localparam int UPD_IMMEDIATE = 0;  // new words take effect at the next edge
  localparam int UPD_ON_WRAP   = 1;  // new words held until the next accumulator wrap

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } upd_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/dsp_lfsr16.sv
// 16-bit Galois LFSR used as a dither source below the NCO truncation point.
// Latency: state updates one clock after en; reset loads the seed on the next edge.
// Backpressure: none; en simply freezes the sequence.
//
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, loads LFSR_SEED
//   en    - advance one step this cycle
//   state - current 16-bit LFSR state
module dsp_lfsr16
  import dsp_nco_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dsp_nco_phase_acc.sv
// NCO phase accumulator + ROM address generator with optional LFSR dither and deferred FCW/POW hop.
// Latency: en at cycle n -> addr/addr_valid at n+1, rom_valid at n+1+ROM_LATENCY.
// Backpressure: cfg_valid/cfg_ready handshake; cfg_ready low only while a deferred update is pending.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   en                - advance accumulator and emit one address
//   sync_clr          - clear phase to 0 (wins over en; addr that cycle is taken from phase 0)
//   cfg_valid/ready   - handshake for a new frequency (cfg_fcw) and phase offset (cfg_pow) word
//   addr, addr_valid  - registered ROM address and its strobe
//   rom_valid         - addr_valid delayed by ROM_LATENCY to line up with ROM sin/cos outputs
//   wrap              - one-cycle pulse when the accumulator carries out
module dsp_nco_phase_acc
  import dsp_nco_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 12,  // must match ROM ADDR_WIDTH, <= ACC_WIDTH
  parameter int DITHER_BITS = 0,   // <= ACC_WIDTH-ADDR_WIDTH and <= 16; 0 disables dither
  parameter int ROM_LATENCY = 1,   // 1 or 2, matching ROM REG_OUT 0/1
  parameter int UPD_MODE    = 0    // UPD_IMMEDIATE or UPD_ON_WRAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ACC_WIDTH-1:0]  cfg_fcw,
  input  logic [ACC_WIDTH-1:0]  cfg_pow,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  output logic                  rom_valid,
  output logic                  wrap
);

  localparam int          TRUNC_SHIFT = ACC_WIDTH - ADDR_WIDTH;
  localparam logic [15:0] DITHER_MASK = 16'((32'd1 << DITHER_BITS) - 32'd1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] fcw_act;
  logic [ACC_WIDTH-1:0] pow_act;
  logic [ACC_WIDTH-1:0] fcw_pend;
  logic [ACC_WIDTH-1:0] pow_pend;
  upd_state_t           state_q;
  upd_state_t           state_d;

  // ---------------------------------------------------------------------------
  // Dither source. Advances on every enabled cycle, sync_clr does not touch it.
  // ---------------------------------------------------------------------------
  logic [15:0]          lfsr_state;
  logic [ACC_WIDTH-1:0] dither;

  dsp_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .state (lfsr_state)
  );

  // Masking the whole state (rather than slicing) keeps DITHER_BITS=0 legal
  // and leaves the unused upper LFSR bits harmlessly folded to zero.
  assign dither = ACC_WIDTH'(lfsr_state & DITHER_MASK);

  // ---------------------------------------------------------------------------
  // Phase arithmetic
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH:0]   acc_sum;    // acc + fcw_act with carry
  logic                 acc_carry;
  logic [ACC_WIDTH-1:0] phase_base;
  logic [ACC_WIDTH-1:0] addr_sum;
  logic                 wrap_evt;

  assign acc_sum   = {1'b0, acc} + {1'b0, fcw_act};
  assign acc_carry = acc_sum[ACC_WIDTH];

  // On a clear cycle the emitted address is taken from phase 0, not from
  // the accumulator value being discarded.
  assign phase_base = sync_clr ? '0 : acc;

  // Dither only perturbs the address lookup; it never enters acc, so the
  // long-term frequency is unaffected.
  assign addr_sum = phase_base + pow_act + dither;

  assign wrap_evt = en & ~sync_clr & acc_carry;

  // ---------------------------------------------------------------------------
  // Configuration update FSM
  // ---------------------------------------------------------------------------
  logic accept;
  logic load_direct;   // immediate mode: cfg words go straight to the active set
  logic load_pend;     // deferred mode: cfg words captured into the pending set
  logic promote;       // deferred mode: pending set becomes active

  assign accept = cfg_valid & cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_direct = 1'b0;
    load_pend   = 1'b0;
    promote     = 1'b0;
    if (UPD_MODE == UPD_IMMEDIATE) begin
      state_d     = ST_IDLE;
      load_direct = accept;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A wrap in the accept cycle is not used; the hop waits for the
          // next carry, which falls out naturally since we only look for
          // wraps once in PEND.
          if (accept) begin
            load_pend = 1'b1;
            state_d   = ST_PEND;
          end
        end
        ST_PEND: begin
          // sync_clr is also a phase discontinuity, so it is a safe point
          // to hop. With fcw_act == 0 it is the only way out of PEND.
          if (sync_clr || wrap_evt) begin
            promote = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // cfg_ready is a flop mirroring the next state so it stays a registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready <= 1'b1;
    end else begin
      cfg_ready <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcw_act  <= '0;
      pow_act  <= '0;
      fcw_pend <= '0;
      pow_pend <= '0;
    end else begin
      if (load_direct) begin
        fcw_act <= cfg_fcw;
        pow_act <= cfg_pow;
      end
      if (promote) begin
        fcw_act <= fcw_pend;
        pow_act <= pow_pend;
      end
      if (load_pend) begin
        fcw_pend <= cfg_fcw;
        pow_pend <= cfg_pow;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator and address register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      addr       <= '0;
      addr_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      addr_valid <= en;
      wrap       <= wrap_evt;
      if (en) begin
        addr <= ADDR_WIDTH'(addr_sum >> TRUNC_SHIFT);
      end
      if (sync_clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc_sum[ACC_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // rom_valid delay line: addr_valid delayed by the ROM read latency.
  // ---------------------------------------------------------------------------
  logic [ROM_LATENCY-1:0] rv_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_sr <= '0;
    end else begin
      rv_sr[0] <= addr_valid;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        rv_sr[k] <= rv_sr[k-1];
      end
    end
  end

  assign rom_valid = rv_sr[ROM_LATENCY-1];

endmodule

// File: tb/tb_dsp_nco_phase_acc.sv
// Self-checking bench for dsp_nco_phase_acc: two instances (immediate update / no dither / ROM latency 1,
// and deferred update / 8 dither bits / ROM latency 2) share randomized stimulus and are compared every
// cycle against a behavioural model, plus a few directed constant checks.
module tb_dsp_nco_phase_acc;

  localparam int AW = 32;
  localparam int DW = 12;
  localparam int N  = 2;

  localparam int C_MODE [N] = '{0, 1};
  localparam int C_DB   [N] = '{0, 8};
  localparam int C_LAT  [N] = '{1, 2};

  logic          clk;
  logic          rst;
  logic          en;
  logic          sync_clr;
  logic          cfg_valid;
  logic [AW-1:0] cfg_fcw;
  logic [AW-1:0] cfg_pow;

  logic          d_rdy  [N];
  logic [DW-1:0] d_addr [N];
  logic          d_av   [N];
  logic          d_rv   [N];
  logic          d_wrap [N];

  int n_checks;
  int n_fail;
  int wrap_cnt [N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dsp_nco_phase_acc #(
    .ACC_WIDTH(AW), .ADDR_WIDTH(DW), .DITHER_BITS(0), .ROM_LATENCY(1), .UPD_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(d_rdy[0]), .cfg_fcw(cfg_fcw), .cfg_pow(cfg_pow),
    .addr(d_addr[0]), .addr_valid(d_av[0]), .rom_valid(d_rv[0]), .wrap(d_wrap[0])
  );

  dsp_nco_phase_acc #(
    .ACC_WIDTH(AW), .ADDR_WIDTH(DW), .DITHER_BITS(8), .ROM_LATENCY(2), .UPD_MODE(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(d_rdy[1]), .cfg_fcw(cfg_fcw), .cfg_pow(cfg_pow),
    .addr(d_addr[1]), .addr_valid(d_av[1]), .rom_valid(d_rv[1]), .wrap(d_wrap[1])
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_acc  [N];
  logic [31:0] m_fcw  [N];
  logic [31:0] m_pow  [N];
  logic [31:0] m_fcwp [N];
  logic [31:0] m_powp [N];
  bit          m_pend [N];
  logic [15:0] m_lfsr [N];
  logic [11:0] m_addr [N];
  bit          m_av   [N];
  bit          m_wrap [N];
  bit          m_rdy  [N];
  bit          m_rv   [N];
  bit          m_hist [N][$];   // past addr_valid values, newest at the back

  // Polynomial x^16+x^14+x^13+x^11+1, right-shifting Galois form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    logic        out;
    out = s[0];
    r   = s >> 1;
    if (out) begin
      r[15] = ~r[15];
      r[13] = ~r[13];
      r[12] = ~r[12];
      r[10] = ~r[10];
    end
    return r;
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      logic [32:0] s;
      logic [31:0] phase;
      logic [31:0] dith;
      bit          carry;
      bit          acc_ok;
      if (rst) begin
        m_acc[i] = 0; m_fcw[i] = 0; m_pow[i] = 0; m_fcwp[i] = 0; m_powp[i] = 0;
        m_pend[i] = 0; m_lfsr[i] = 16'hACE1; m_addr[i] = 0; m_av[i] = 0;
        m_wrap[i] = 0; m_rdy[i] = 1; m_rv[i] = 0;
        m_hist[i].delete();
        continue;
      end
      acc_ok = cfg_valid && m_rdy[i];
      s      = 33'(m_acc[i]) + 33'(m_fcw[i]);
      carry  = s[32];
      dith   = 32'(m_lfsr[i]) % (32'd1 << C_DB[i]);
      phase  = (sync_clr ? 32'd0 : m_acc[i]) + m_pow[i] + dith;

      // rom_valid is the addr_valid seen C_LAT cycles earlier.
      m_hist[i].push_back(m_av[i]);
      if (m_hist[i].size() >= C_LAT[i]) m_rv[i] = m_hist[i][m_hist[i].size() - C_LAT[i]];
      else                              m_rv[i] = 0;
      if (m_hist[i].size() > 4) void'(m_hist[i].pop_front());

      if (en) m_addr[i] = phase / (32'd1 << (AW - DW));
      m_av[i]   = en;
      m_wrap[i] = en && !sync_clr && carry;
      if (sync_clr)  m_acc[i] = 0;
      else if (en)   m_acc[i] = s[31:0];
      if (en) m_lfsr[i] = lfsr_step(m_lfsr[i]);

      if (C_MODE[i] == 0) begin
        if (acc_ok) begin
          m_fcw[i] = cfg_fcw;
          m_pow[i] = cfg_pow;
        end
        m_rdy[i] = 1;
      end else begin
        if (m_pend[i]) begin
          if (sync_clr || (en && carry)) begin
            m_fcw[i]  = m_fcwp[i];
            m_pow[i]  = m_powp[i];
            m_pend[i] = 0;
          end
        end else if (acc_ok) begin
          m_fcwp[i] = cfg_fcw;
          m_powp[i] = cfg_pow;
          m_pend[i] = 1;
        end
        m_rdy[i] = !m_pend[i];
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("addr%0d", i),       32'(d_addr[i]), 32'(m_addr[i]));
      chk($sformatf("addr_valid%0d", i), 32'(d_av[i]),   32'(m_av[i]));
      chk($sformatf("rom_valid%0d", i),  32'(d_rv[i]),   32'(m_rv[i]));
      chk($sformatf("wrap%0d", i),       32'(d_wrap[i]), 32'(m_wrap[i]));
      chk($sformatf("cfg_ready%0d", i),  32'(d_rdy[i]),  32'(m_rdy[i]));
      if (d_wrap[i] === 1'b1) wrap_cnt[i]++;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit c, input bit v,
                       input logic [31:0] f, input logic [31:0] p);
    @(negedge clk);
    rst = r; en = e; sync_clr = c; cfg_valid = v; cfg_fcw = f; cfg_pow = p;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] pick_fcw();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0100_0000;
      2:       return 32'h0200_0000;
      3:       return 32'h8000_0000;
      4:       return 32'h000F_FF80;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_pow();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h4000_0000;
      2:       return 32'h000F_FF80;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_fcw = '0; cfg_pow = '0;

    // Reset state.
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0);

    // Basic ramp: FCW = 2^24 -> addr step 16, wrap every 256 enabled cycles.
    cycle(0, 0, 0, 1, 32'h0100_0000, 32'h0);
    cycle(0, 0, 1, 0, 32'h0, 32'h0);   // releases the deferred instance
    for (int i = 0; i < N; i++) wrap_cnt[i] = 0;
    for (int k = 0; k < 512; k++) cycle(0, 1, 0, 0, 0, 0);
    chk("ramp_wraps0", 32'(wrap_cnt[0]), 32'd2);
    chk("ramp_wraps1", 32'(wrap_cnt[1]), 32'd2);

    // Phase offset: POW = quarter turn, FCW = 0 -> addr fixed at 1024.
    cycle(0, 0, 0, 1, 32'h0, 32'h4000_0000);
    cycle(0, 0, 1, 0, 32'h0, 32'h0);
    for (int i = 0; i < N; i++) wrap_cnt[i] = 0;
    for (int k = 0; k < 6; k++) cycle(0, 1, 0, 0, 0, 0);
    chk("pow_addr0", 32'(d_addr[0]), 32'd1024);
    chk("pow_addr1", 32'(d_addr[1]), 32'd1024);
    chk("fcw0_nowrap0", 32'(wrap_cnt[0]), 32'd0);
    chk("fcw0_nowrap1", 32'(wrap_cnt[1]), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 6000; k++) begin
      bit r, e, c, v;
      r = ($urandom_range(0, 499) == 0);
      e = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 19) == 0);
      cycle(r, e, c, v, pick_fcw(), pick_pow());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
